// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the shared 7-segment display scheduler:
//   - SEG_* bit positions of the abcdefgh pin bus (bit7 = a .. bit1 = g, bit0 = h/dp)
//   - share_state_t : arbiter states (IDLE = nobody owns the display, OWN = owned)
//   - hex_to_7seg() : hex nibble to segment pattern (0-9, A, b, C, d, E, F), dp off
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int SEG_A = 7;
   localparam int SEG_B = 6;
   localparam int SEG_C = 5;
   localparam int SEG_D = 4;
   localparam int SEG_E = 3;
   localparam int SEG_F = 2;
   localparam int SEG_G = 1;
   localparam int SEG_H = 0;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } share_state_t;

   // Segment pattern for one hex digit; the decimal point bit is always off here.
   function automatic logic [7:0] hex_to_7seg(input logic [3:0] nib);
      logic [6:0] p;   // abcdefg
      logic [7:0] seg;
      case (nib)
         4'h0:    p = 7'b1111110;
         4'h1:    p = 7'b0110000;
         4'h2:    p = 7'b1101101;
         4'h3:    p = 7'b1111001;
         4'h4:    p = 7'b0110011;
         4'h5:    p = 7'b1011011;
         4'h6:    p = 7'b1011111;
         4'h7:    p = 7'b1110000;
         4'h8:    p = 7'b1111111;
         4'h9:    p = 7'b1111011;
         4'hA:    p = 7'b1110111;
         4'hB:    p = 7'b0011111;
         4'hC:    p = 7'b1001110;
         4'hD:    p = 7'b0111101;
         4'hE:    p = 7'b1001111;
         4'hF:    p = 7'b1000111;
         default: p = 7'b0000000;
      endcase
      seg        = 8'h00;
      seg[SEG_A] = p[6];
      seg[SEG_B] = p[5];
      seg[SEG_C] = p[4];
      seg[SEG_D] = p[3];
      seg[SEG_E] = p[2];
      seg[SEG_F] = p[1];
      seg[SEG_G] = p[0];
      seg[SEG_H] = 1'b0;
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Free-running digit scanner for an 8-digit multiplexed display. Each digit gets
// a slot of SLOT_CYC cycles whose first BLANK_CYC cycles are dark (anti-ghosting).
// Pins are registered, so they lag the slot/digit counters by one cycle.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   i_active           : 1 = an owner holds the display; 0 = keep everything dark
//   i_snap_val/dp/blank: frame snapshot (nibble k -> digit k, blank bit 1 = dark)
//   o_frame_end        : combinational, high in the last counter cycle of a frame
//   o_frame_tick       : registered frame_end, aligned with the pins
//   o_abcdefgh, o_digit: segment and one-hot digit pins
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SLOT_CYC  = 3375,
   parameter int BLANK_CYC = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_active,
   input  logic [31:0] i_snap_val,
   input  logic [7:0]  i_snap_dp,
   input  logic [7:0]  i_snap_blank,
   output logic        o_frame_end,
   output logic        o_frame_tick,
   output logic [7:0]  o_abcdefgh,
   output logic [7:0]  o_digit
);

   localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
   localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);

   logic [SW-1:0] r_slot_cnt;
   logic [2:0]    r_digit_idx;
   logic          r_frame_tick;
   logic [7:0]    r_abcdefgh;
   logic [7:0]    r_digit;

   logic          w_slot_end;
   logic          w_lit;
   logic [3:0]    w_nibble;
   logic [7:0]    w_seg;

   assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
   assign o_frame_end = w_slot_end && (r_digit_idx == 3'd7);

   // Slot and digit counters; the 3-bit digit index wraps 7 -> 0 by itself.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_slot_cnt  <= {SW{1'b0}};
         r_digit_idx <= 3'd0;
      end else if (w_slot_end) begin
         r_slot_cnt  <= {SW{1'b0}};
         r_digit_idx <= r_digit_idx + 3'd1;
      end else begin
         r_slot_cnt  <= r_slot_cnt + SW'(1);
         r_digit_idx <= r_digit_idx;
      end
   end

   // Segment pattern for the current digit and whether it may light at all.
   always_comb begin
      w_nibble     = i_snap_val[{r_digit_idx, 2'b00} +: 4];
      w_seg        = hex_to_7seg(w_nibble);
      w_seg[SEG_H] = i_snap_dp[r_digit_idx];
      w_lit        = i_active && (r_slot_cnt >= BLANK_END) && !i_snap_blank[r_digit_idx];
   end

   // Registered pin drive; reset clears the pins immediately through the async path.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_frame_tick <= 1'b0;
         r_abcdefgh   <= 8'h00;
         r_digit      <= 8'h00;
      end else begin
         r_frame_tick <= o_frame_end;
         r_abcdefgh   <= w_lit ? w_seg : 8'h00;
         r_digit      <= w_lit ? (8'h01 << r_digit_idx) : 8'h00;
      end
   end

   assign o_frame_tick = r_frame_tick;
   assign o_abcdefgh   = r_abcdefgh;
   assign o_digit      = r_digit;

endmodule

// File: rtl/seg7_share_scheduler.sv
// -----------------------------------------------------------------------------
// seg7_share_scheduler
// Shares one 8-digit multiplexed 7-segment display between N_REQ requesters with
// round-robin arbitration and a minimum ownership time of HOLD_FRAMES frames
// (only enforced while someone else is waiting). Ownership changes and the
// value/dp/blank snapshot are taken only at frame boundaries, so digits never tear.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   i_req        : level request per requester
//   i_value      : requester i hex value at [32*i +: 32], nibble k -> digit k
//   i_dp         : requester i decimal-point mask at [8*i +: 8]
//   i_blank      : requester i digit-blank mask at [8*i +: 8], 1 = digit dark
//   o_grant      : one-hot current owner, zero when idle
//   o_frame_tick : one-cycle pulse on the last pin cycle of every frame
//   o_abcdefgh   : bit7 = a .. bit1 = g, bit0 = dp; 1 = segment on
//   o_digit      : one-hot active digit, 0 = none
// -----------------------------------------------------------------------------
module seg7_share_scheduler
   import seg7_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int SLOT_CYC    = 3375,
   parameter int BLANK_CYC   = 64,
   parameter int HOLD_FRAMES = 100
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_REQ*32-1:0]  i_value,
   input  logic [N_REQ*8-1:0]   i_dp,
   input  logic [N_REQ*8-1:0]   i_blank,
   output logic [N_REQ-1:0]     o_grant,
   output logic                 o_frame_tick,
   output logic [7:0]           o_abcdefgh,
   output logic [7:0]           o_digit
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

   // Next index round-robin, wrapping N_REQ-1 -> 0 (N_REQ need not be a power of 2).
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
      return (x == LAST_IDX) ? {IW{1'b0}} : (x + IW'(1));
   endfunction

   // First requester at or after 'start' in round-robin order; returns {found, index}.
   function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IW-1:0] start);
      logic          found;
      logic [IW-1:0] idx;
      logic [IW-1:0] pick;
      found = 1'b0;
      pick  = {IW{1'b0}};
      idx   = start;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end else begin
            found = found;
         end
         idx = wrap_inc(idx);
      end
      return {found, pick};
   endfunction

   share_state_t     r_state;
   share_state_t     w_state_nxt;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    w_owner_nxt;
   logic [IW-1:0]    r_rr_ptr;
   logic [IW-1:0]    w_rr_nxt;
   logic [HW-1:0]    r_hold_cnt;
   logic [HW-1:0]    w_hold_nxt;
   logic             w_load;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] w_grant_nxt;
   logic [N_REQ-1:0] w_owner_mask;
   logic             w_others;
   logic [IW:0]      w_pick_rr;
   logic [IW:0]      w_pick_next;
   logic [31:0]      w_sel_val;
   logic [7:0]       w_sel_dp;
   logic [7:0]       w_sel_blank;
   logic [31:0]      r_snap_val;
   logic [7:0]       r_snap_dp;
   logic [7:0]       r_snap_blank;
   logic             w_frame_end;

   assign w_owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
   assign w_others     = |(i_req & ~w_owner_mask);
   assign w_pick_rr    = rr_pick(i_req, r_rr_ptr);
   assign w_pick_next  = rr_pick(i_req, wrap_inc(r_owner));

   // Arbiter decisions, taken only in the last counter cycle of a frame.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_ptr;
      w_hold_nxt  = r_hold_cnt;
      w_load      = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            IDLE: begin
               if (w_pick_rr[IW]) begin
                  w_state_nxt = OWN;
                  w_owner_nxt = w_pick_rr[IW-1:0];
                  w_rr_nxt    = wrap_inc(w_pick_rr[IW-1:0]);
                  w_hold_nxt  = {HW{1'b0}};
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            OWN: begin
               if (!i_req[r_owner]) begin
                  // Owner released: hand over, or fall idle when nobody else wants it.
                  if (w_pick_next[IW]) begin
                     w_owner_nxt = w_pick_next[IW-1:0];
                     w_rr_nxt    = wrap_inc(w_pick_next[IW-1:0]);
                     w_hold_nxt  = {HW{1'b0}};
                     w_load      = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                     w_hold_nxt  = {HW{1'b0}};
                  end
               end else if (w_others && (r_hold_cnt >= HOLD_MAX)) begin
                  // Someone else waits and the minimum ownership has elapsed;
                  // w_pick_next cannot return the owner because another req is set.
                  w_owner_nxt = w_pick_next[IW-1:0];
                  w_rr_nxt    = wrap_inc(w_pick_next[IW-1:0]);
                  w_hold_nxt  = {HW{1'b0}};
                  w_load      = 1'b1;
               end else begin
                  // Keep the owner and refresh its snapshot for the next frame.
                  w_load = 1'b1;
                  if (r_hold_cnt < HOLD_MAX) begin
                     w_hold_nxt = r_hold_cnt + HW'(1);
                  end else begin
                     w_hold_nxt = r_hold_cnt;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_hold_nxt  = {HW{1'b0}};
            end
         endcase
      end else begin
         w_load = 1'b0;
      end
   end

   // One-hot grant for the owner chosen for the next frame.
   always_comb begin
      if (w_state_nxt == OWN) begin
         w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_owner_nxt;
      end else begin
         w_grant_nxt = {N_REQ{1'b0}};
      end
   end

   // Input mux for the snapshot: the newly selected owner's value/dp/blank.
   always_comb begin
      w_sel_val   = 32'h0000_0000;
      w_sel_dp    = 8'h00;
      w_sel_blank = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_owner_nxt == IW'(i)) begin
            w_sel_val   = i_value[32*i +: 32];
            w_sel_dp    = i_dp[8*i +: 8];
            w_sel_blank = i_blank[8*i +: 8];
         end else begin
            w_sel_val   = w_sel_val;
         end
      end
   end

   // Arbiter state, owner, round-robin pointer, hold counter and grant.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= {IW{1'b0}};
         r_rr_ptr   <= {IW{1'b0}};
         r_hold_cnt <= {HW{1'b0}};
         r_grant    <= {N_REQ{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_grant    <= w_grant_nxt;
      end
   end

   // Frame snapshot; stays frozen for the whole frame even if the owner lets go.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_snap_val   <= 32'h0000_0000;
         r_snap_dp    <= 8'h00;
         r_snap_blank <= 8'h00;
      end else if (w_load) begin
         r_snap_val   <= w_sel_val;
         r_snap_dp    <= w_sel_dp;
         r_snap_blank <= w_sel_blank;
      end else begin
         r_snap_val   <= r_snap_val;
         r_snap_dp    <= r_snap_dp;
         r_snap_blank <= r_snap_blank;
      end
   end

   seg7_scan_driver #(
      .SLOT_CYC  (SLOT_CYC),
      .BLANK_CYC (BLANK_CYC)
   ) u_scan (
      .clock        (clock),
      .reset        (reset),
      .i_active     (r_state == OWN),
      .i_snap_val   (r_snap_val),
      .i_snap_dp    (r_snap_dp),
      .i_snap_blank (r_snap_blank),
      .o_frame_end  (w_frame_end),
      .o_frame_tick (o_frame_tick),
      .o_abcdefgh   (o_abcdefgh),
      .o_digit      (o_digit)
   );

   assign o_grant = r_grant;

endmodule
